seq_digit_multiplier: RTL
=========================

# seq_digit_multiplier

Sequential shift-and-add multiplier for two single-digit operands (0–9), producing a 7-bit binary product (0–81). It sits directly upstream of the binary-to-BCD converter and drives that converter's 7-bit input. Operands are captured on a start request, multiplied over four iteration cycles, and the registered product is held stable for display until the next result. Out-of-range operands produce a fixed error code, which the downstream converter maps to its error pattern.

## Interface
- MAX_OPERAND, 9: largest legal operand value; anything above it is an error.
- ERR_CODE, 7'd127: product value emitted on an operand error. Must lie outside 0..81.
- clk  input  1  single system clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous and active-low
- start  input  1  request to multiply; sampled only in IDLE
- op_a  input  4  multiplicand, legal range 0..MAX_OPERAND
- op_b  input  4  multiplier, legal range 0..MAX_OPERAND
- busy  output  1  high while state is not IDLE; decoded from state
- done  output  1  one-cycle pulse when product/err update
- err  output  1  registered; high if the last accepted op_a or op_b exceeded MAX_OPERAND
- product  output  7  registered result; feeds the binary-to-BCD input

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- **IDLE**:
  - start=1 captures op_a into M and op_b into Q.
  - It clears the 8-bit accumulator and the 2-bit iteration counter.
  - It latches the range flag: range_bad = (op_a>MAX_OPERAND) or (op_b>MAX_OPERAND).
  - Next state is CALC.
- **CALC**, one iteration per cycle:
  - If Q[0]=1, acc <= acc + (M << cnt).
  - Q shifts right by 1 and cnt increments.
  - When cnt==3 the state moves to DONE; exactly 4 iterations run.
- **DONE**:
  - If range_bad, product <= ERR_CODE and err <= 1.
  - Otherwise product <= acc[6:0] and err <= 0.
  - done <= 1 for this edge only. Next state is IDLE.
- **Width rules**:
  - The accumulator is 8 bits, so 15×15=225 cannot overflow internally.
  - For legal operands acc ≤ 81, so bit 7 is never set.
  - acc[7] is ignored. Truncation is safe because illegal operands are overridden by ERR_CODE.
- **Latency**: uniform for legal and illegal operands; no early exit.
- **start handling**:
  - start during CALC or DONE is ignored. It is neither queued nor able to corrupt operands.
  - Operand changes after capture have no effect.
- **product and err** hold their value between results. They change only at the DONE edge or on reset.

## Timing
- **Reset** (rst_n=0 at a rising edge):
  - state=IDLE, product=0, err=0, done=0, busy=0.
  - acc, Q, M and cnt are cleared.
- **Reset mid-operation**: the calculation is aborted with no done pulse, and product returns to 0 on the reset edge.
- **Latency**, for start sampled at edge k in IDLE:
  - Edges k+1..k+4 are CALC iterations.
  - At edge k+5 product, err and done update.
  - done is high for exactly the cycle k+5..k+6.
- busy is high from after edge k until edge k+5.
- The earliest next accepted start is at edge k+6. A start held high continuously therefore yields one result every 6 cycles.
- start at edge k+5 (state DONE) is ignored.
- product is valid whenever done=1 and remains valid afterwards. The downstream converter may sample it combinationally at any time.

## Test plan
- Reset, then start with op_a=9, op_b=9 -> done at k+5, product=81, err=0, busy high for exactly 5 cycles.
- Legal products:
  - op_a=6, op_b=7 -> product=42.
  - op_a=0, op_b=7 -> product=0.
  - op_a=9, op_b=1 -> product=9.
  - Each has err=0 and a single-cycle done.
- op_a=10, op_b=3 -> product=127, err=1 at k+5. A following 2×3 clears it: product=6, err=0.
- Start with op_a=4, op_b=5:
  - Change operands to 9,9 and pulse start at k+2 -> product=20, only one done.
  - A start at k+6 with 9,9 -> product=81 at k+11.
- Start 8×8, then assert rst_n=0 at k+3 -> no done, product=0, busy=0 next cycle. A new 3×3 then gives product=9.
- start held high with 7×8 -> done every 6 cycles, product=56 each time, never glitching between pulses.

Source files
------------

// File: rtl/seq_digit_multiplier.sv
// ----------------------------------------------------------------------------
// seq_digit_multiplier
//
// Multiplies two single-digit operands (0..MAX_OPERAND) one multiplier bit per
// cycle and keeps the 7-bit product registered so a downstream
// binary-to-BCD converter can sample it at any time.
//
// A start seen in IDLE captures both operands and the range flag. Four CALC
// cycles follow, then a DONE cycle that publishes product/err and pulses done.
// Every operation takes the same number of cycles, legal operands or not.
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   multiply request, only honoured in IDLE
//   op_a     in   [3:0] multiplicand
//   op_b     in   [3:0] multiplier
//   busy     out  high whenever the FSM is not in IDLE
//   done     out  single-cycle pulse when product/err are updated
//   err      out  registered, set when the last accepted operand was too large
//   product  out  [6:0] registered product, or ERR_CODE on an operand error
// ----------------------------------------------------------------------------
module seq_digit_multiplier #(
  parameter logic [3:0] MAX_OPERAND = 4'd9,
  parameter logic [6:0] ERR_CODE    = 7'd127
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q,     state_d;
  logic [3:0] m_q,         m_d;
  logic [3:0] q_q,         q_d;
  logic [7:0] acc_q,       acc_d;
  logic [1:0] cnt_q,       cnt_d;
  logic       range_bad_q, range_bad_d;
  logic [6:0] product_q,   product_d;
  logic       err_q,       err_d;
  logic       done_q,      done_d;

  // Multiplicand widened to accumulator width before shifting, so M << 3
  // keeps its upper bits.
  logic [7:0] m_ext;
  assign m_ext = {4'b0000, m_q};

  // NOTE: every next-state value gets a default first, so the combinational
  // block holds state through the _q registers and never infers a latch.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    q_d         = q_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    range_bad_d = range_bad_q;
    product_d   = product_q;
    err_d       = err_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d         = op_a;
          q_d         = op_b;
          acc_d       = 8'd0;
          cnt_d       = 2'd0;
          range_bad_d = (op_a > MAX_OPERAND) || (op_b > MAX_OPERAND);
          state_d     = ST_CALC;
        end
      end

      ST_CALC: begin
        if (q_q[0]) begin
          acc_d = acc_q + (m_ext << cnt_q);
        end
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 2'd1;
        // Fixed four iterations: no early exit when Q runs out of ones,
        // so latency never depends on the operands.
        if (cnt_q == 2'd3) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // acc[7] can only be set by out-of-range operands, which are replaced
        // by ERR_CODE here, so dropping it is safe.
        if (range_bad_q) begin
          product_d = ERR_CODE;
          err_d     = 1'b1;
        end else begin
          product_d = acc_q[6:0];
          err_d     = 1'b0;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      m_q         <= 4'd0;
      q_q         <= 4'd0;
      acc_q       <= 8'd0;
      cnt_q       <= 2'd0;
      range_bad_q <= 1'b0;
      product_q   <= 7'd0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      q_q         <= q_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      range_bad_q <= range_bad_d;
      product_q   <= product_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign product = product_q;

endmodule
